// File: rtl/sha256_pkg.sv
// Shared constants, types and round functions for the SHA-256 stream core.
// SHA256_SHA224_EN enables the SHA-224 IV selection in the top module.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_HOLD  = 2'd3
    } sha256_state_e;

    // Eight 32-bit words; a..h for the working set, H0..H7 for the chaining value.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } sha256_work_t;

    localparam sha256_work_t IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam sha256_work_t IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch_f(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj_f(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Lane-wise 32-bit wrap-around addition of two word sets.
    function automatic sha256_work_t add_work(input sha256_work_t x, input sha256_work_t y);
        sha256_work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; chained in the top for unrolling.
module sha256_round
    import sha256_pkg::*;
(
    input  sha256_work_t state_in,
    input  logic [31:0]  k_t,
    input  logic [31:0]  w_t,
    output sha256_work_t state_out
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = state_in.h + bsig1(state_in.e) + ch_f(state_in.e, state_in.f, state_in.g) + k_t + w_t;
        t2 = bsig0(state_in.a) + maj_f(state_in.a, state_in.b, state_in.c);
        state_out.a = t1 + t2;
        state_out.b = state_in.a;
        state_out.c = state_in.b;
        state_out.d = state_in.c;
        state_out.e = state_in.d + t1;
        state_out.f = state_in.e;
        state_out.g = state_in.f;
        state_out.h = state_in.g;
    end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine: chains H across blocks, ROUNDS_PER_CYCLE rounds per clock.
// Define SHA256_SHA224_EN to add the mode_224 port and SHA-224 IV/truncation.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blk_valid,
    output logic          blk_ready,
    input  logic [511:0]  blk_data,
    input  logic          blk_first,
    input  logic          blk_last,
    output logic          digest_valid,
    input  logic          digest_ready,
    output logic [255:0]  digest,
`ifdef SHA256_SHA224_EN
    input  logic          mode_224,
`endif
    output sha256_state_e dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid is only dropped after that edge, and ready never depends on valid.

    localparam logic [5:0] LAST_CNT = 6'(64 - ROUNDS_PER_CYCLE);

    sha256_state_e state, state_next;
    logic [5:0]    round_cnt;
    logic [31:0]   w [16];
    logic [31:0]   w_shift [16];
    sha256_work_t  work;
    sha256_work_t  hash;
    sha256_work_t  hash_sum;
    sha256_work_t  iv_sel;
    sha256_work_t  chain [ROUNDS_PER_CYCLE+1];
    logic          last_r;

`ifdef SHA256_SHA224_EN
    logic mode_r;
    assign iv_sel = mode_224 ? IV_224 : IV_256;
`else
    assign iv_sel = IV_256;
`endif

    assign blk_ready    = (state == ST_IDLE);
    assign digest_valid = (state == ST_HOLD);
    assign dbg_state    = state;
    assign hash_sum     = add_work(hash, work);

    assign chain[0] = work;
    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
        sha256_round u_round (
            .state_in  (chain[r]),
            .k_t       (K[round_cnt + 6'(r)]),
            .w_t       (w[r]),
            .state_out (chain[r+1])
        );
    end

    // Extend the window by the words the next cycle needs, then drop the consumed ones.
    always_comb begin
        logic [31:0] ext [16+ROUNDS_PER_CYCLE];
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int i = 16; i < 16 + ROUNDS_PER_CYCLE; i++)
            ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
        for (int i = 0; i < 16; i++) w_shift[i] = ext[i+ROUNDS_PER_CYCLE];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (blk_valid) state_next = ST_ROUND;
            ST_ROUND: if (round_cnt == LAST_CNT) state_next = ST_FINAL;
            ST_FINAL: state_next = last_r ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (digest_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            round_cnt <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            work      <= '0;
            hash      <= IV_256;
            digest    <= '0;
            last_r    <= 1'b0;
`ifdef SHA256_SHA224_EN
            mode_r    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) w[i] <= blk_data[511-32*i -: 32];
                        last_r    <= blk_last;
                        round_cnt <= '0;
                        if (blk_first) begin
                            work <= iv_sel;
                            hash <= iv_sel;
`ifdef SHA256_SHA224_EN
                            mode_r <= mode_224;
`endif
                        end else begin
                            work <= hash;
                        end
                    end
                end
                ST_ROUND: begin
                    work      <= chain[ROUNDS_PER_CYCLE];
                    w         <= w_shift;
                    round_cnt <= round_cnt + 6'(ROUNDS_PER_CYCLE);
                end
                ST_FINAL: begin
                    hash <= hash_sum;
`ifdef SHA256_SHA224_EN
                    if (last_r) digest <= mode_r ? {hash_sum[255:32], 32'h0} : hash_sum;
`else
                    if (last_r) digest <= hash_sum;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core: three instances (R = 1, 2, 4) on a shared clock.
// Covers known-answer vectors, timing, back-to-back, backpressure, abort; SHA-224 under SHA256_SHA224_EN.
module tb_sha256_stream_core;
    import sha256_pkg::*;

    localparam int N_DUT = 3;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] TWO_B1    = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2    = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_DUT-1:0]     blk_valid;
    logic [N_DUT-1:0]     blk_ready;
    logic [511:0]         blk_data [N_DUT];
    logic [N_DUT-1:0]     blk_first;
    logic [N_DUT-1:0]     blk_last;
    logic [N_DUT-1:0]     digest_valid;
    logic [N_DUT-1:0]     digest_ready;
    logic [255:0]         digest [N_DUT];
    sha256_state_e        dbg_state [N_DUT];
`ifdef SHA256_SHA224_EN
    logic [N_DUT-1:0]     mode_224;
`endif

    logic [255:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .blk_valid    (blk_valid[g]),
            .blk_ready    (blk_ready[g]),
            .blk_data     (blk_data[g]),
            .blk_first    (blk_first[g]),
            .blk_last     (blk_last[g]),
            .digest_valid (digest_valid[g]),
            .digest_ready (digest_ready[g]),
            .digest       (digest[g]),
`ifdef SHA256_SHA224_EN
            .mode_224     (mode_224[g]),
`endif
            .dbg_state    (dbg_state[g])
        );
    end

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns just after the accepting posedge.
    // waited = number of negedges on which blk_ready was seen low.
    task automatic drive_block(input int i, input logic [511:0] data, input logic first,
                               input logic last, output int waited);
        blk_valid[i] = 1'b1;
        blk_data[i]  = data;
        blk_first[i] = first;
        blk_last[i]  = last;
        waited = 0;
        while (!blk_ready[i] && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!blk_ready[i]) check($sformatf("accept_timeout_%0d", i), 256'(blk_ready[i]), 256'(1));
        @(posedge clk);
    endtask

    // Drops blk_valid and scrambles the block inputs, which the core must ignore.
    task automatic release_blk(input int i);
        blk_valid[i] = 1'b0;
        for (int k = 0; k < 16; k++) blk_data[i][32*k +: 32] = $urandom();
        blk_first[i] = 1'($urandom_range(0, 1));
        blk_last[i]  = 1'($urandom_range(0, 1));
    endtask

    // Latency counts cycles from the acceptance cycle through the edge that raises
    // digest_valid (accept at T, FINAL at T+64/R+1 -> 64/R+2).
    task automatic finish_last(input int i, input int exp_lat);
        int lat;
        @(negedge clk);
        release_blk(i);
        check($sformatf("ready_low_in_round_%0d", i), 256'(blk_ready[i]), 256'(0));
        lat = 1;
        while (!digest_valid[i] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("digest_latency_%0d", i), 256'(lat), 256'(exp_lat));
    endtask

    task automatic send_last(input int i, input logic [511:0] data, input logic first,
                             input logic [255:0] exp_dig);
        int waited;
        drive_block(i, data, first, 1'b1, waited);
        exp_q.push_back(exp_dig);
        finish_last(i, 64 / (1 << i) + 2);
    endtask

    // Called at a negedge with digest_valid high; completes the handshake.
    task automatic receive_digest(input int i);
        logic [255:0] exp;
        if (exp_q.size() == 0) begin
            check($sformatf("sb_underflow_%0d", i), 256'(exp_q.size()), 256'(1));
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check($sformatf("digest_%0d", i), digest[i], exp);
        digest_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready[i] = 1'b0;
        check($sformatf("valid_drop_%0d", i), 256'(digest_valid[i]), 256'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        int high_cnt;
        reset        = 1'b1;
        blk_valid    = '0;
        blk_first    = '0;
        blk_last     = '0;
        digest_ready = '0;
        for (int i = 0; i < N_DUT; i++) blk_data[i] = '0;
`ifdef SHA256_SHA224_EN
        mode_224     = '0;
`endif
        repeat (3) @(negedge clk);

        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("rst_blk_ready_%0d", i), 256'(blk_ready[i]), 256'(1));
            check($sformatf("rst_digest_valid_%0d", i), 256'(digest_valid[i]), 256'(0));
            check($sformatf("rst_digest_%0d", i), digest[i], 256'(0));
            check($sformatf("rst_state_%0d", i), 256'(dbg_state[i]), 256'(ST_IDLE));
        end
        reset = 1'b0;
        @(negedge clk);

        // "abc" single block on every unroll factor
        for (int i = 0; i < N_DUT; i++) begin
            send_last(i, ABC_BLK, 1'b1, ABC_DIG);
            receive_digest(i);
        end

        // empty message
        send_last(0, EMPTY_BLK, 1'b1, EMPTY_DIG);
        receive_digest(0);

        // two-block message with blk_valid held high across both blocks
        for (int i = 0; i < N_DUT; i += 2) begin
            drive_block(i, TWO_B1, 1'b1, 1'b0, waited);
            @(negedge clk);
            drive_block(i, TWO_B2, 1'b0, 1'b1, waited);
            check($sformatf("b2b_wait_%0d", i), 256'(waited), 256'(64 / (1 << i) + 1));
            exp_q.push_back(TWO_DIG);
            finish_last(i, 64 / (1 << i) + 2);
            receive_digest(i);
        end

        // backpressure: digest held 20 cycles while another block is offered
        send_last(1, ABC_BLK, 1'b1, ABC_DIG);
        blk_valid[1] = 1'b1;
        blk_data[1]  = EMPTY_BLK;
        blk_first[1] = 1'b1;
        blk_last[1]  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("hold_digest_stable", digest[1], ABC_DIG);
            check("hold_blk_ready", 256'(blk_ready[1]), 256'(0));
            @(negedge clk);
        end
        receive_digest(1);
        drive_block(1, EMPTY_BLK, 1'b1, 1'b1, waited);
        check("accept_after_handshake", 256'(waited), 256'(0));
        exp_q.push_back(EMPTY_DIG);
        finish_last(1, 34);
        receive_digest(1);

        // reset in the middle of ROUND discards the block
        drive_block(2, ABC_BLK, 1'b1, 1'b1, waited);
        @(negedge clk);
        release_blk(2);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_blk_ready", 256'(blk_ready[2]), 256'(1));
        check("abort_state", 256'(dbg_state[2]), 256'(ST_IDLE));
        reset = 1'b0;
        high_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (digest_valid[2]) high_cnt++;
        end
        check("abort_no_digest", 256'(high_cnt), 256'(0));
        send_last(2, EMPTY_BLK, 1'b1, EMPTY_DIG);
        receive_digest(2);

        // after reset H is the IV, so a non-first "abc" still gives the abc digest
        send_last(1, ABC_BLK, 1'b0, ABC_DIG);
        receive_digest(1);

`ifdef SHA256_SHA224_EN
        mode_224[0] = 1'b1;
        send_last(0, ABC_BLK, 1'b1,
                  256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000);
        receive_digest(0);
        mode_224[0] = 1'b0;
        send_last(0, ABC_BLK, 1'b1, ABC_DIG);
        receive_digest(0);
`endif

        check("sb_drained", 256'(exp_q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Multi-block SHA-256 compression engine with valid/ready handshakes on the block input and digest output. It chains the intermediate hash across consecutive 512-bit blocks, so it can hash arbitrary-length pre-padded messages. Its throughput can be scaled by unrolling the rounds. It sits between the padding/message front-end and the digest consumer.

## Interface
- ROUNDS_PER_CYCLE, default 1: compression rounds evaluated per clock. Legal values are 1, 2 and 4.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- blk_valid  in  1  block offered
- blk_ready  out  1  core accepts a block this cycle
- blk_data  in  512  padded block; W[0] = [511:480], W[15] = [31:0]
- blk_first  in  1  block starts a new message; H is loaded from the IV
- blk_last  in  1  block ends the message; a digest is produced
- digest_valid  out  1  digest available
- digest_ready  in  1  consumer takes the digest
- digest  out  256  H0 in [255:224] … H7 in [31:0]
- mode_224  in  1  selects the SHA-224 IV; this port exists only with SHA256_SHA224_EN

## Operation
- **States:** IDLE, ROUND, FINAL, HOLD.
- **IDLE**
  - blk_ready = 1.
  - On blk_valid, latch blk_data into the 16-word rolling schedule buffer and latch blk_first, blk_last and mode_224.
  - If blk_first, load the working registers a..h and the chaining H from the IV. Otherwise load a..h from the current H.
  - Round counter = 0; go to ROUND.
- **ROUND**
  - Each cycle, perform ROUNDS_PER_CYCLE rounds, in order, using K[t] and W[t].
  - W[t] for t ≥ 16 = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - The schedule buffer shifts by ROUNDS_PER_CYCLE words per cycle. No 64-word array.
  - Round counter advances by ROUNDS_PER_CYCLE. After round 63, go to FINAL.
- **FINAL**
  - H[i] ← H[i] + working register i, mod 2^32, one cycle.
  - If blk_last: digest ← new H and go to HOLD. Otherwise go to IDLE.
- **HOLD**
  - digest_valid = 1; blk_ready = 0.
  - On digest_ready, digest_valid ← 0 and go to IDLE.
  - digest is held stable while digest_valid = 1.
- **Boundary rules**
  - blk_first is sampled only at acceptance. blk_first with no prior message is legal.
  - A non-first block after a last block chains from the previous digest. This is not an error.
  - blk_first = 1 and blk_last = 1 on the same block hashes a single-block message.
  - blk_data and the flags are ignored when blk_ready = 0.
  - digest_ready outside HOLD is ignored.
  - All additions are 32-bit wrap-around.

## Timing
- **Reset values:** blk_ready = 1, digest_valid = 0, digest = 0, state IDLE, H = SHA-256 IV.
- **Reset mid-operation:** the block in flight is discarded; no digest is produced.
- **Per-block timing:** block accepted on edge T. Rounds occupy edges T+1 … T+64/R. FINAL occurs on edge T+64/R+1.
- **Digest latency:** for a last block, digest_valid rises after edge T+64/R+1. That is 66 cycles for R = 1, 34 for R = 2, 18 for R = 4.
- **Back-to-back:**
  - For non-last blocks, blk_ready returns after FINAL. The next acceptance is at T+64/R+2.
  - For last blocks, the next acceptance is one cycle after the digest handshake at the earliest.
- **Digest handshake:** completes on an edge with digest_valid & digest_ready both high. digest_valid is low from the next cycle.

## Configuration
- **SHA256_SHA224_EN defined:**
  - The mode_224 port exists and is latched with blk_first. mode_224 on non-first blocks is ignored; the message keeps its latched mode.
  - When the latched mode is 1:
    - The IV is the SHA-224 IV (c1059ed8 … befa4fa4).
    - digest[255:32] = H0..H6 and digest[31:0] = 0.
- **Undefined:** no mode_224 port; SHA-256 only.

## Structure
- **Package sha256_pkg:**
  - K[0:63].
  - SHA-256 and SHA-224 IV constants.
  - State enum.
  - σ0/σ1/Σ0/Σ1/ch/maj functions.
- **Sub-module sha256_round:** one combinational round taking a..h, K, W and producing the next a..h. It is instantiated ROUNDS_PER_CYCLE times in a chain.
- The schedule buffer and the FSM stay in the top module.

## Test plan
- **"abc" single block** (first = last = 1), for each R in {1, 2, 4}: digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad. digest_valid rises 66/34/18 cycles after acceptance.
- **Empty message** (block 80000000, zeros, length 0): digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"**, blk_valid held high throughout: digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. blk_ready is low during rounds.
- **Backpressure:** digest_ready held 0 for 20 cycles after "abc". digest stays stable, blk_ready stays 0, and a new blk_valid is not accepted until one cycle after digest_ready = 1.
- **Reset asserted mid-ROUND on "abc"**, followed by a fresh empty message: no digest_valid from the aborted block, and the empty-message digest is correct.
- **SHA256_SHA224_EN, mode_224 = 1, "abc":** digest = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
